// File: rtl/cost_frame_ctrl.sv
// Frame sequencer for a streaming cost datapath: primes the pipeline, runs the frame,
// flushes the latency with padded taps, and tracks the raster coordinate of each valid output.
module cost_frame_ctrl #(
  parameter int unsigned W           = 11,
  parameter int unsigned PRIME_ROWS  = 5,
  parameter int unsigned PRIME_EXTRA = 1
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] width,
  input  logic [W-1:0] height,
  input  logic         pix_valid,
  input  logic         ds_ready,
  output logic         clken,
  output logic         pad,
  output logic         out_valid,
  output logic [W-1:0] out_col,
  output logic [W-1:0] out_row,
  output logic         busy,
  output logic         frame_done,
  output logic         cfg_err
);

  localparam int unsigned CW = 2 * W + 3;

  typedef enum logic [2:0] {StIdle, StPrime, StRun, StFlush, StDone} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  width_q, width_d, height_q, height_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [W-1:0]  col_q, col_d, row_q, row_d;
  logic [W-1:0]  last_col_q, last_col_d, last_row_q, last_row_d;
  logic          cfg_err_q, cfg_err_d;

  logic [CW-1:0] prime_len, total, in_cnt_inc, out_cnt_inc;
  logic          cfg_ok;

  assign prime_len   = CW'(PRIME_ROWS) * CW'(width_q) + CW'(PRIME_EXTRA);
  assign total       = CW'(width_q) * CW'(height_q);
  assign in_cnt_inc  = in_cnt_q + CW'(1);
  assign out_cnt_inc = out_cnt_q + CW'(1);
  assign cfg_ok      = (width >= W'(3)) && (height != '0);

  always_comb begin
    clken = 1'b0;
    unique case (state_q)
      StPrime, StRun: clken = pix_valid & ds_ready & ~abort;
      StFlush:        clken = ds_ready & ~abort;
      default:        clken = 1'b0;
    endcase
  end

  assign out_valid  = clken & ((state_q == StRun) | (state_q == StFlush));
  assign pad        = (state_q == StFlush);
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StDone);
  assign cfg_err    = cfg_err_q;
  // During a valid cycle show the pixel being emitted, otherwise hold the last one.
  assign out_col    = out_valid ? col_q : last_col_q;
  assign out_row    = out_valid ? row_q : last_row_q;

  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    height_d   = height_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    last_col_d = last_col_q;
    last_row_d = last_row_q;
    cfg_err_d  = 1'b0;

    if (abort) begin
      if (state_q != StIdle) begin
        state_d    = StIdle;
        in_cnt_d   = '0;
        out_cnt_d  = '0;
        col_d      = '0;
        row_d      = '0;
        last_col_d = '0;
        last_row_d = '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_ok) begin
              state_d   = StPrime;
              width_d   = width;
              height_d  = height;
              in_cnt_d  = '0;
              out_cnt_d = '0;
              col_d     = '0;
              row_d     = '0;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        StPrime: begin
          if (clken) begin
            in_cnt_d = in_cnt_inc;
            // A frame no larger than the prime depth never reaches RUN.
            if (in_cnt_inc == total) begin
              state_d = StFlush;
            end else if (in_cnt_inc == prime_len) begin
              state_d = StRun;
            end
          end
        end
        StRun: begin
          if (clken) begin
            in_cnt_d = in_cnt_inc;
            if (in_cnt_inc == total) begin
              state_d = StFlush;
            end
          end
        end
        StFlush: begin
          if (out_valid && (out_cnt_inc == total)) begin
            state_d = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase

      if (out_valid) begin
        out_cnt_d  = out_cnt_inc;
        last_col_d = col_q;
        last_row_d = row_q;
        if (col_q == width_q - W'(1)) begin
          col_d = '0;
          row_d = row_q + W'(1);
        end else begin
          col_d = col_q + W'(1);
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= StIdle;
      width_q    <= '0;
      height_q   <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      last_col_q <= '0;
      last_row_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      height_q   <= height_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      last_col_q <= last_col_d;
      last_row_q <= last_row_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_cost_frame_ctrl.sv
// Scoreboard bench for cost_frame_ctrl: frames push expected raster coordinates, a negedge
// monitor pops them on every out_valid; frame-level counts are checked against fixed values.
module tb_cost_frame_ctrl;

  localparam int W = 11;

  logic         sys_clk = 1'b0;
  logic         sys_rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] width = '0;
  logic [W-1:0] height = '0;
  logic         pix_valid = 1'b0;
  logic         ds_ready = 1'b0;
  logic         clken, pad, out_valid, busy, frame_done, cfg_err;
  logic [W-1:0] out_col, out_row;

  int exp_col[$];
  int exp_row[$];
  int n_cmp = 0;
  int n_bad = 0;
  int mc, mr;

  cost_frame_ctrl #(.W(W), .PRIME_ROWS(5), .PRIME_EXTRA(1)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .abort      (abort),
    .width      (width),
    .height     (height),
    .pix_valid  (pix_valid),
    .ds_ready   (ds_ready),
    .clken      (clken),
    .pad        (pad),
    .out_valid  (out_valid),
    .out_col    (out_col),
    .out_row    (out_row),
    .busy       (busy),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({clken, pad, out_valid, out_col, out_row, busy, frame_done, cfg_err});
  endfunction

  // Monitor: pops the scoreboard on each valid output.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      if (!ds_ready) check("clken_without_ready", clken, 0);
      if (out_valid) begin
        if (exp_col.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out_valid: got col %0d row %0d, expected no output",
                   out_col, out_row);
        end else begin
          mc = exp_col.pop_front();
          mr = exp_row.pop_front();
          check("out_col", out_col, mc);
          check("out_row", out_row, mr);
        end
      end
    end
  end

  // Entered and left at posedge+1. abort_at: assert abort on that input index.
  // rst_at: assert reset after that many flush cycles.
  task automatic run_frame(input int w, input int h, input bit rnd, input int abort_at,
                           input int rst_at, output int n_valid, output int n_flush,
                           output int first_in, output int gap);
    int n_in = 0;
    int last_v = 0;
    bit ab = 1'b0;
    n_valid = 0;
    n_flush = 0;
    first_in = 0;
    gap = 0;
    if (abort_at == 0) begin
      for (int r = 0; r < h; r++) begin
        for (int c = 0; c < w; c++) begin
          exp_col.push_back(c);
          exp_row.push_back(r);
        end
      end
    end
    start = 1'b1;
    width = W'(w);
    height = W'(h);
    pix_valid = 1'b1;
    ds_ready = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ds_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (abort_at != 0 && n_in == abort_at - 1) begin
        abort = 1'b1;
        ab = 1'b1;
      end
      if (cyc == 10 && abort_at == 0) begin
        start = 1'b1;
        width = W'(2);
      end else begin
        start = 1'b0;
      end
      @(negedge sys_clk);
      if (cyc == 1) check("busy_in_frame", busy, 1);
      if (cyc == 11 && abort_at == 0) check("cfg_err_while_busy", cfg_err, 0);
      if (clken && !pad) n_in++;
      if (out_valid) begin
        n_valid++;
        last_v = cyc;
        if (first_in == 0) first_in = n_in;
      end
      if (clken && pad) n_flush++;
      if (ab) begin
        @(posedge sys_clk); #1;
        abort = 1'b0;
        @(negedge sys_clk);
        check("abort_busy", busy, 0);
        check("abort_clken", clken, 0);
        check("abort_frame_done", frame_done, 0);
        @(posedge sys_clk); #1;
        return;
      end
      if (rst_at != 0 && n_flush == rst_at) begin
        #1 sys_rst = 1'b0;
        #1 check("async_reset_outputs", out_vec(), 0);
        exp_col.delete();
        exp_row.delete();
        @(posedge sys_clk); #1;
        check("held_reset_outputs", out_vec(), 0);
        sys_rst = 1'b1;
        return;
      end
      if (frame_done) begin
        gap = cyc - last_v;
        @(posedge sys_clk); #1;
        check("idle_after_done", busy, 0);
        return;
      end
      @(posedge sys_clk); #1;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL frame_timeout: got no frame_done, expected one within 3000 cycles");
  endtask

  task automatic check_full(input string tag, input int w, input int h, input bit rnd,
                            input int exp_first, input int exp_flush);
    int nv, nf, fi, gp;
    run_frame(w, h, rnd, 0, 0, nv, nf, fi, gp);
    check({tag, "_valid_count"}, nv, w * h);
    check({tag, "_flush_cycles"}, nf, exp_flush);
    check({tag, "_first_valid_input"}, fi, exp_first);
    check({tag, "_done_gap"}, gp, 1);
    check({tag, "_final_col"}, out_col, w - 1);
    check({tag, "_final_row"}, out_row, h - 1);
  endtask

  initial begin
    int nv, nf, fi, gp;
    start = 1'b1;
    width = W'(8);
    height = W'(8);
    pix_valid = 1'b1;
    ds_ready = 1'b1;
    #12;
    check("reset_outputs", out_vec(), 0);
    @(posedge sys_clk); #1;
    check("reset_outputs_after_edge", out_vec(), 0);
    start = 1'b0;
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;

    // Rejected configurations
    start = 1'b1; width = W'(2); height = W'(4);
    @(posedge sys_clk); #1;
    start = 1'b0;
    @(negedge sys_clk);
    check("cfg_err_narrow", cfg_err, 1);
    check("busy_after_reject", busy, 0);
    @(posedge sys_clk); #1;
    check("cfg_err_one_cycle", cfg_err, 0);
    start = 1'b1; width = W'(5); height = W'(0);
    @(posedge sys_clk); #1;
    start = 1'b0;
    check("cfg_err_zero_height", cfg_err, 1);
    check("busy_after_reject2", busy, 0);
    start = 1'b1; abort = 1'b1; width = W'(8); height = W'(8);
    @(posedge sys_clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle_busy", busy, 0);
    check("start_abort_idle_cfg", cfg_err, 0);

    // Two back-to-back 8x8 frames, then a tiny frame that skips RUN
    check_full("f8a", 8, 8, 1'b0, 42, 41);
    check_full("f8b", 8, 8, 1'b0, 42, 41);
    check_full("f3x1", 3, 1, 1'b0, 3, 3);
    check_full("f5x3", 5, 3, 1'b0, 15, 15);
    check_full("f8rnd", 8, 8, 1'b1, 42, 41);

    // Abort on input 20, restart two cycles later
    run_frame(8, 8, 1'b0, 20, 0, nv, nf, fi, gp);
    check("abort_no_outputs", nv, 0);
    @(posedge sys_clk); #1;
    check_full("f8post_abort", 8, 8, 1'b0, 42, 41);

    // Reset during FLUSH, then start on the first edge after release
    run_frame(8, 8, 1'b0, 0, 5, nv, nf, fi, gp);
    check("flush_reached_before_reset", nf, 5);
    check("idle_after_reset", busy, 0);
    check_full("f3x1post_rst", 3, 1, 1'b0, 3, 3);

    pix_valid = 1'b0;
    ds_ready = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    check("scoreboard_empty", exp_col.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cost_frame_ctrl.md
COST_FRAME_CTRL -- requirements
Module: cost_frame_ctrl

Interface
REQ-001 SHALL have parameter W, default 11, meaning the bit width of the width, height and coordinate fields.
REQ-002 SHALL have parameter PRIME_ROWS, default 5, meaning the number of full rows the cost datapath must absorb before its first valid output.
REQ-003 SHALL have parameter PRIME_EXTRA, default 1, meaning the number of extra pixels absorbed beyond PRIME_ROWS rows before the first valid output.
REQ-004 sys_clk  in  1  sole clock; all logic rising-edge.
REQ-005 sys_rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  single-cycle frame request; honoured only in IDLE.
REQ-007 abort  in  1  synchronous frame cancel; wins over every other input except sys_rst.
REQ-008 width  in  W  pixels per row; sampled when start is accepted.
REQ-009 height  in  W  rows per frame; sampled when start is accepted.
REQ-010 pix_valid  in  1  upstream pixel present on the tap lines this cycle.
REQ-011 ds_ready  in  1  downstream can take a cost vector this cycle.
REQ-012 clken  out  1  advance enable to the cost datapath.
REQ-013 pad  out  1  high while flushing; upstream taps are forced to zero.
REQ-014 out_valid  out  1  the cost vector on the datapath output is a real pixel.
REQ-015 out_col  out  W  column of the current output pixel.
REQ-016 out_row  out  W  row of the current output pixel.
REQ-017 busy  out  1  high when state is not IDLE.
REQ-018 frame_done  out  1  one-cycle pulse marking the end of a frame.
REQ-019 cfg_err  out  1  one-cycle pulse marking a rejected start.

Function
REQ-020 FSM states SHALL be IDLE, PRIME, RUN, FLUSH and DONE; encoding is free.
REQ-021 In IDLE, start with width>=3 and height>=1 SHALL latch width and height and go to PRIME the next cycle.
REQ-022 In IDLE, start with width<3 or height==0 SHALL pulse cfg_err for 1 cycle and remain in IDLE.
REQ-023 start while busy SHALL be ignored, with no cfg_err.
REQ-024 P SHALL equal PRIME_ROWS*width_latched+PRIME_EXTRA, computed at full precision (2W+3 bits minimum).
REQ-025 In PRIME and RUN, clken SHALL equal pix_valid & ds_ready (combinational).
REQ-026 In FLUSH, clken SHALL equal ds_ready; in IDLE and DONE, clken SHALL be 0.
REQ-027 pad SHALL be 1 exactly in FLUSH.
REQ-028 in_cnt SHALL count clken cycles in PRIME/RUN; PRIME SHALL go to RUN on the clken cycle that makes in_cnt equal P.
REQ-029 out_valid SHALL be 1 only on cycles where clken=1 and the state is RUN or FLUSH, and in RUN only after the P-th input.
REQ-030 The first out_valid SHALL fall on the (P+1)-th input clken cycle.
REQ-031 RUN SHALL go to FLUSH on the clken cycle that makes in_cnt equal width*height.
REQ-032 If width*height<=P, PRIME SHALL go directly to FLUSH on that cycle.
REQ-033 FLUSH SHALL issue clken cycles until the total count of out_valid cycles equals width*height, then go to DONE.
REQ-034 The number of flush clken cycles SHALL be min(P, width*height).
REQ-035 out_col/out_row SHALL start at 0/0 and advance on each out_valid cycle.
REQ-036 out_col SHALL wrap to 0 after width-1 and out_row SHALL increment at the same time.
REQ-037 out_col/out_row SHALL show the coordinate of the current valid output and hold their value between valid outputs.
REQ-038 DONE SHALL last 1 cycle, pulse frame_done, and go to IDLE.
REQ-039 A start in the cycle after DONE (state IDLE) SHALL be accepted.
REQ-040 ds_ready=0 SHALL freeze all counters and the FSM, except for abort.
REQ-041 pix_valid=0 SHALL have the same freezing effect in PRIME and RUN.
REQ-042 abort in any busy state SHALL go to IDLE the next cycle, clearing the counters, with no frame_done.
REQ-043 A simultaneous start+abort in IDLE SHALL be ignored.

Reset
REQ-044 While sys_rst=0: state=IDLE, counters=0, latched width/height=0.
REQ-045 While sys_rst=0: clken=0, pad=0, out_valid=0, out_col=0, out_row=0, busy=0, frame_done=0, cfg_err=0.
REQ-046 Reset assertion mid-frame SHALL take effect immediately (asynchronous).
REQ-047 Release of reset SHALL be sampled synchronously; the first start is accepted on the first sys_clk edge after release.

Verification
REQ-048 width=8, height=8, pix_valid=ds_ready=1 -> first out_valid on input cycle 42; FLUSH lasts 41 cycles; 64 out_valid cycles; final out_col/out_row=7/7; frame_done 1 cycle later.
REQ-049 width=2, start -> cfg_err pulse; busy stays 0. Then width=3, height=1 -> P=16>3, PRIME->FLUSH after 3 inputs, 3 flush cycles, 3 out_valid cycles.
REQ-050 Random ds_ready/pix_valid at 50% on an 8x8 frame -> clken never 1 while ds_ready=0; exactly 64 out_valid; coordinates raster-ordered with no skips.
REQ-051 abort at input cycle 20 of an 8x8 frame -> next cycle busy=0, clken=0, no frame_done; a new start two cycles later runs a full correct frame.
REQ-052 sys_rst low during FLUSH -> all outputs 0 in the same cycle; after release, IDLE with start accepted.
REQ-053 Back-to-back frames: start in the cycle after frame_done -> accepted; second frame output identical to the first.
